// File: rtl/program_memory.sv
// Instruction store with power-up clear sequence, write-first bypass and
// optional per-word even parity (enabled by PROGRAM_MEMORY_PARITY_EN).
module program_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 28,
    parameter int DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD = 28'h40000AA
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iReadEnable,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    input  logic                  iWriteEnable,
    input  logic [ADDR_WIDTH-1:0] iWriteAddress,
    input  logic [DATA_WIDTH-1:0] iWriteData,
    input  logic                  iWriteParityFlip,
    output logic                  oReady,
    output logic                  oParityError
);

`ifdef PROGRAM_MEMORY_PARITY_EN
    localparam int SW = DATA_WIDTH + 1;
`else
    localparam int SW = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;

    logic [SW-1:0]         mem [DEPTH];

    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [SW-1:0]         wword;
    logic                  wr_in;
    logic                  rd_in;
    logic                  byp;
    logic [SW-1:0]         rword;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_perr;

`ifndef PROGRAM_MEMORY_PARITY_EN
    logic unused_flip;
    assign unused_flip = iWriteParityFlip;
`endif

    assign wr_in  = 32'(iWriteAddress) < 32'(DEPTH);
    assign rd_in  = 32'(iAddress) < 32'(DEPTH);
    assign oReady = (state_q == READY);

    // State and clear-counter registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear walks every implemented word once, then hands over to READY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                cnt_d = '0;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Single write port: clear writes during CLEAR, program loads in READY
    always_comb begin
        wen   = 1'b0;
        waddr = cnt_q;
`ifdef PROGRAM_MEMORY_PARITY_EN
        wword = {^FILL_WORD, FILL_WORD};
`else
        wword = FILL_WORD;
`endif
        if (state_q == CLEAR) begin
            wen = 1'b1;
        end else if (iWriteEnable && wr_in) begin
            wen   = 1'b1;
            waddr = iWriteAddress;
`ifdef PROGRAM_MEMORY_PARITY_EN
            wword = {^iWriteData ^ iWriteParityFlip, iWriteData};
`else
            wword = iWriteData;
`endif
        end
    end

    // Storage array, deliberately not reset (CLEAR rewrites it)
    always_ff @(posedge Clock) begin
        if (wen) begin
            mem[waddr] <= wword;
        end
    end

    assign byp = (state_q == READY) && wen && (iWriteAddress == iAddress);

    // Fetch data select: bypass, array, or fill for unimplemented addresses
    always_comb begin
        rword   = mem[iAddress];
        rd_data = FILL_WORD;
        rd_perr = 1'b0;
        if (byp) begin
            rd_data = iWriteData;
`ifdef PROGRAM_MEMORY_PARITY_EN
            rd_perr = iWriteParityFlip;
`endif
        end else if (rd_in) begin
            rd_data = rword[DATA_WIDTH-1:0];
`ifdef PROGRAM_MEMORY_PARITY_EN
            rd_perr = (^rword[DATA_WIDTH-1:0]) ^ rword[SW-1];
`endif
        end
    end

    // Registered fetch result; held while no fetch is accepted
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oInstruction <= FILL_WORD;
            oValid       <= 1'b0;
            oParityError <= 1'b0;
        end else if ((state_q == READY) && iReadEnable) begin
            oInstruction <= rd_data;
            oValid       <= 1'b1;
            oParityError <= rd_perr;
        end else begin
            oValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: clear timing, loads, bypass,
// out-of-range handling (DEPTH=200 instance), parity and mid-stream reset.
module tb_program_memory;

    localparam logic [27:0] FILL = 28'h40000AA;
`ifdef PROGRAM_MEMORY_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iReadEnable;
    logic [7:0]  iAddress;
    logic        iWriteEnable;
    logic [7:0]  iWriteAddress;
    logic [27:0] iWriteData;
    logic        iWriteParityFlip;

    logic [27:0] oInstruction;
    logic        oValid;
    logic        oReady;
    logic        oParityError;
    logic [27:0] oInstruction2;
    logic        oValid2;
    logic        oReady2;
    logic        oParityError2;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    program_memory dut (
        .Clock(Clock), .Reset(Reset),
        .iReadEnable(iReadEnable), .iAddress(iAddress),
        .oInstruction(oInstruction), .oValid(oValid),
        .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress),
        .iWriteData(iWriteData), .iWriteParityFlip(iWriteParityFlip),
        .oReady(oReady), .oParityError(oParityError)
    );

    program_memory #(.DEPTH(200)) dut2 (
        .Clock(Clock), .Reset(Reset),
        .iReadEnable(iReadEnable), .iAddress(iAddress),
        .oInstruction(oInstruction2), .oValid(oValid2),
        .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress),
        .iWriteData(iWriteData), .iWriteParityFlip(iWriteParityFlip),
        .oReady(oReady2), .oParityError(oParityError2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        iReadEnable = 1'b1;
        iAddress = 8'h05;
        iWriteEnable = 1'b0;
        iWriteAddress = 8'h00;
        iWriteData = '0;
        iWriteParityFlip = 1'b0;

        #12;
        chk("rst_instr", 32'(oInstruction), 32'(FILL));
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_ready", 32'(oReady), 0);
        chk("rst_perr", 32'(oParityError), 0);

        @(posedge Clock);
        #1 Reset = 1'b1;

        for (int i = 1; i <= 256; i++) begin
            tick();
            chk("clr_valid", 32'(oValid), 0);
            chk("clr_ready", 32'(oReady), (i == 256) ? 1 : 0);
            if (i == 199 || i == 200)
                chk("clr_ready200", 32'(oReady2), (i == 200) ? 1 : 0);
        end

        tick();
        chk("first_rd_data", 32'(oInstruction), 32'(FILL));
        chk("first_rd_valid", 32'(oValid), 1);

        iReadEnable = 1'b0;
        iWriteEnable = 1'b1;
        iWriteAddress = 8'h03;
        iWriteData = 28'h1234567;
        tick();
        chk("idle_valid", 32'(oValid), 0);
        chk("idle_hold", 32'(oInstruction), 32'(FILL));

        iWriteEnable = 1'b0;
        iReadEnable = 1'b1;
        iAddress = 8'h03;
        tick();
        chk("wr3_data", 32'(oInstruction), 32'h1234567);
        chk("wr3_valid", 32'(oValid), 1);
        chk("wr3_perr", 32'(oParityError), 0);

        iWriteEnable = 1'b1;
        iWriteAddress = 8'h10;
        iWriteData = 28'h0ABCDEF;
        iAddress = 8'h10;
        tick();
        chk("byp_data", 32'(oInstruction), 32'h0ABCDEF);
        chk("byp_valid", 32'(oValid), 1);
        chk("byp_perr", 32'(oParityError), 0);

        iReadEnable = 1'b0;
        iWriteAddress = 8'hC8;
        iWriteData = 28'h1111111;
        tick();
        iWriteAddress = 8'hC7;
        iWriteData = 28'h2222222;
        tick();
        iWriteEnable = 1'b0;
        iReadEnable = 1'b1;
        iAddress = 8'hC8;
        tick();
        chk("c8_d256", 32'(oInstruction), 32'h1111111);
        chk("c8_d200", 32'(oInstruction2), 32'(FILL));
        chk("c8_d200_valid", 32'(oValid2), 1);
        chk("c8_d200_perr", 32'(oParityError2), 0);
        iAddress = 8'hC7;
        tick();
        chk("c7_d200", 32'(oInstruction2), 32'h2222222);

        iReadEnable = 1'b0;
        iWriteEnable = 1'b1;
        iWriteAddress = 8'h07;
        iWriteData = 28'h0000001;
        iWriteParityFlip = 1'b1;
        tick();
        iWriteEnable = 1'b0;
        iWriteParityFlip = 1'b0;
        iReadEnable = 1'b1;
        iAddress = 8'h07;
        tick();
        chk("flip_data", 32'(oInstruction), 32'h0000001);
        chk("flip_perr", 32'(oParityError), 32'(PAR));

        iReadEnable = 1'b0;
        tick();
        chk("hold_valid", 32'(oValid), 0);
        chk("hold_data", 32'(oInstruction), 32'h0000001);
        chk("hold_perr", 32'(oParityError), 32'(PAR));

        iReadEnable = 1'b1;
        iWriteEnable = 1'b1;
        iWriteAddress = 8'h20;
        iWriteData = 28'h0000005;
        iWriteParityFlip = 1'b1;
        iAddress = 8'h20;
        tick();
        chk("bypflip_data", 32'(oInstruction), 32'h0000005);
        chk("bypflip_perr", 32'(oParityError), 32'(PAR));
        iWriteEnable = 1'b0;
        iWriteParityFlip = 1'b0;

        iAddress = 8'h00;
        tick();
        chk("s0_data", 32'(oInstruction), 32'(FILL));
        chk("s0_perr", 32'(oParityError), 0);
        iAddress = 8'h03;
        tick();
        chk("s3_data", 32'(oInstruction), 32'h1234567);
        chk("s3_valid", 32'(oValid), 1);
        iAddress = 8'h01;
        tick();
        chk("s1_data", 32'(oInstruction), 32'(FILL));
        chk("s1_valid", 32'(oValid), 1);
        iAddress = 8'h03;
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(oValid), 0);
        chk("mid_rst_data", 32'(oInstruction), 32'(FILL));
        chk("mid_rst_ready", 32'(oReady), 0);
        @(posedge Clock);
        #1 Reset = 1'b1;

        for (int i = 1; i <= 256; i++) begin
            tick();
            chk("reclr_valid", 32'(oValid), 0);
            if (i >= 255)
                chk("reclr_ready", 32'(oReady), (i == 256) ? 1 : 0);
        end
        tick();
        chk("recleared_data", 32'(oInstruction), 32'(FILL));
        chk("recleared_valid", 32'(oValid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
